ifu_fetch: RTL
==============

Name: ifu_fetch

Overview:
- Multi-cycle instruction fetch unit; directly upstream of the decode-stage bus register.
- Holds the PC and issues one read per instruction on an AXI4-Lite-style read channel (AR/R).
- Presents inst/pc/snpc downstream with valid/ready, then waits for the next PC from writeback before fetching again.
- Exactly one fetch outstanding at any time.

Parameters:
- RESET_PC, 32'h8000_0000, PC loaded on reset.
- INST_W, 32, instruction/address width; fixed at 32, any other value unsupported.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- araddr  out  32  fetch address (= pc)
- arvalid  out  1  address valid
- arready  in  1  memory accepts address
- rdata  in  32  instruction word
- rresp  in  2  response code, 2'b00 = OKAY
- rvalid  in  1  read data valid
- rready  out  1  IFU accepts data
- instF  out  32  fetched instruction
- pcF  out  32  PC of instF
- snpcF  out  32  pcF + 4
- m_valid  out  1  instF/pcF/snpcF valid to decode
- m_ready  in  1  decode accepts
- npc  in  32  next PC from writeback
- npc_valid  in  1  npc valid
- npc_ready  out  1  IFU accepts npc
- fetch_fault  out  1  access fault on the current instruction (see Optional Feature)

Behaviour:
- Reset is synchronous, active-high, clock clk. While rst is high:
  - pc <= RESET_PC; state <= S_AR.
  - instF <= 0, pcF <= RESET_PC, snpcF <= 0, fetch_fault <= 0.
  - arvalid, rready, m_valid and npc_ready read 0 during rst.
- States:
  - S_AR: arvalid=1, araddr=pc. Goes to S_R when arready is high. araddr is stable while arvalid && !arready.
  - S_R: rready=1. On rvalid, capture instF<=rdata, pcF<=pc, snpcF<=pc+4 (mod 2^32, wraps), fault flag; go to S_OUT.
  - S_OUT: m_valid=1, outputs held stable. Goes to S_NPC when m_ready is high.
  - S_NPC: npc_ready=1. On npc_valid, pc<=npc and go to S_AR.
- Outputs are Moore, decoded from state only. No combinational path from any input to arvalid, rready, m_valid or npc_ready.
- Latency with zero-wait memory and an always-ready consumer:
  - arvalid at cycle 0; rvalid at cycle 1 at the earliest; m_valid at cycle 2.
  - npc accepted at cycle 3 at the earliest; next arvalid at cycle 4.
- arready and rvalid may arrive in the same cycle. rvalid is only sampled in S_R, so the response is consumed one cycle later. Memory must hold rvalid/rdata until rready (standard AXI).
- npc_valid outside S_NPC is ignored; the bench asserts that it does not occur.
- An npc with bits[1:0] != 0 is fetched as given. Alignment checking is not an IFU responsibility.
- rst asserted mid-transaction abandons any pending AR/R. Memory must also be reset by the same rst.

Optional Feature:
- Macro IFU_ACCESS_FAULT_EN.
- Defined:
  - rresp != 2'b00 at capture sets fetch_fault=1 in S_OUT.
  - instF is forced to 32'h0000_0013 (NOP); pcF/snpcF are captured normally.
  - fetch_fault clears on the next capture.
- Undefined:
  - rresp is ignored and rdata is passed through.
  - fetch_fault is tied to 0.

Decomposition:
- Shared package (config.vh-style header):
  - state encodings S_AR/S_R/S_OUT/S_NPC (2-bit);
  - RESP_OKAY = 2'b00;
  - NOP_INST = 32'h0000_0013;
  - RESET_PC default.
- No sub-module needed. The state register, pc register and output register live in one module.

Test Plan:
- Reset release, zero-wait memory, m_ready=1, npc=0x80000004 one cycle after npc_ready → araddr=0x80000000 at cycle 0; m_valid at cycle 2 with pcF=0x80000000 and snpcF=0x80000004; second araddr=0x80000004.
- arready delayed 3 cycles, rvalid delayed 5 cycles after handshake → araddr stable throughout; one capture only; instF equals the returned rdata 0x00100093.
- m_ready held low 4 cycles in S_OUT → m_valid stays 1 and instF/pcF unchanged; no new arvalid until an npc is accepted.
- Pulse npc_valid in S_R and S_OUT → ignored; pc changes only on the npc handshake in S_NPC; redirect npc=0x80000100 yields araddr=0x80000100.
- pc=0xFFFFFFFC → snpcF=0x00000000. Assert rst during S_R → next arvalid has araddr=0x80000000 and m_valid stays 0.
- With IFU_ACCESS_FAULT_EN: rresp=2'b10, rdata=0xDEADBEEF → instF=0x00000013, fetch_fault=1; the next OKAY fetch clears it. Without the macro: instF=0xDEADBEEF, fetch_fault=0.

Source files
------------

// File: rtl/ifu_fetch_pkg.sv
// Shared definitions for the instruction fetch unit: FSM state encoding,
// response codes and reset/NOP constants.
package ifu_fetch_pkg;

    // Fetch sequencing: address, response, present downstream, wait next PC.
    typedef enum logic [1:0] {
        S_AR  = 2'd0,
        S_R   = 2'd1,
        S_OUT = 2'd2,
        S_NPC = 2'd3
    } fetch_state_e;

    localparam logic [1:0]  RESP_OKAY        = 2'b00;
    localparam logic [31:0] NOP_INST         = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;

    // Sequential next PC; wraps modulo 2^32.
    function automatic logic [31:0] seq_pc(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/ifu_fetch.sv
// Multi-cycle instruction fetch unit. Issues one AR/R read per instruction,
// presents inst/pc/snpc to decode, then waits for the next PC from writeback.
// Only one fetch is ever outstanding.
//
// Optional feature macro: IFU_ACCESS_FAULT_EN
//   defined   - a non-OKAY rresp at capture raises fetch_fault and replaces the
//               instruction with a NOP; the flag clears on the next capture.
//   undefined - rresp is ignored, rdata passes through, fetch_fault is 0.
//
// INST_W is fixed at 32; other widths are not supported.
module ifu_fetch
    import ifu_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int unsigned INST_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    // Read address channel
    output logic [INST_W-1:0] araddr,
    output logic              arvalid,
    input  logic              arready,
    // Read data channel
    input  logic [INST_W-1:0] rdata,
    input  logic [1:0]        rresp,
    input  logic              rvalid,
    output logic              rready,
    // Downstream to decode
    output logic [INST_W-1:0] instF,
    output logic [INST_W-1:0] pcF,
    output logic [INST_W-1:0] snpcF,
    output logic              m_valid,
    input  logic              m_ready,
    // Next PC from writeback
    input  logic [INST_W-1:0] npc,
    input  logic              npc_valid,
    output logic              npc_ready,
    output logic              fetch_fault
);

    fetch_state_e      state_q;
    // Low while in reset and for the reset cycle itself, so every handshake
    // output reads 0 during rst without a combinational path from rst.
    logic              active_q;
    logic [INST_W-1:0] pc_q;
    logic [INST_W-1:0] inst_q;
    logic [INST_W-1:0] pcf_q;
    logic [INST_W-1:0] snpcf_q;
    logic [INST_W-1:0] snpc_d;

`ifdef IFU_ACCESS_FAULT_EN
    logic              fault_q;
`endif

    assign snpc_d = seq_pc(pc_q);

    // Single FSM: state, PC and the registered decode-side outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_AR;
            active_q <= 1'b0;
            pc_q     <= RESET_PC;
            inst_q   <= '0;
            pcf_q    <= RESET_PC;
            snpcf_q  <= '0;
`ifdef IFU_ACCESS_FAULT_EN
            fault_q  <= 1'b0;
`endif
        end else begin
            active_q <= 1'b1;
            if (active_q) begin
                unique case (state_q)
                    S_AR: begin
                        if (arready) begin
                            state_q <= S_R;
                        end
                    end
                    S_R: begin
                        if (rvalid) begin
                            pcf_q   <= pc_q;
                            snpcf_q <= snpc_d;
`ifdef IFU_ACCESS_FAULT_EN
                            if (rresp != RESP_OKAY) begin
                                inst_q  <= NOP_INST;
                                fault_q <= 1'b1;
                            end else begin
                                inst_q  <= rdata;
                                fault_q <= 1'b0;
                            end
`else
                            inst_q  <= rdata;
`endif
                            state_q <= S_OUT;
                        end
                    end
                    S_OUT: begin
                        if (m_ready) begin
                            state_q <= S_NPC;
                        end
                    end
                    S_NPC: begin
                        if (npc_valid) begin
                            pc_q    <= npc;
                            state_q <= S_AR;
                        end
                    end
                    default: state_q <= S_AR;
                endcase
            end
        end
    end

    // Moore handshake outputs decoded from registered state only.
    always_comb begin
        arvalid   = active_q && (state_q == S_AR);
        rready    = active_q && (state_q == S_R);
        m_valid   = active_q && (state_q == S_OUT);
        npc_ready = active_q && (state_q == S_NPC);
    end

    assign araddr = pc_q;
    assign instF  = inst_q;
    assign pcF    = pcf_q;
    assign snpcF  = snpcf_q;

`ifdef IFU_ACCESS_FAULT_EN
    assign fetch_fault = fault_q;
`else
    // Response code has no effect without fault reporting.
    logic unused_rresp;
    assign unused_rresp = ^rresp;
    assign fetch_fault  = 1'b0;
`endif

endmodule
